cpu_state_dumper: RTL

Hardware counterpart to the bench-side state printout. On a trigger it freezes the CPU pipeline. It then streams the PC, all 32 architectural registers and the first MEM_WORDS data-memory words as tagged 32-bit words over a valid/ready interface. It sits beside `CPU`, tapping the PC, a spare register-file read port and a spare data-memory read port, and feeds a debug link or capture FIFO.

---
 rtl/cpu_state_dumper.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: on trigger, freezes the CPU and streams PC, x0..x31 and
// the first MEM_WORDS data-memory words as tagged 32-bit words.
// Latency: first word valid one cycle after the trigger edge, then one word per
// accepted handshake. Backpressure: the word, tag and read addresses hold while
// out_ready_i is low; valid is never withdrawn mid-dump.
module cpu_state_dumper #(
    parameter int MEM_WORDS = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trig_i,
    input  logic [31:0] pc_i,
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_data_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic        freeze_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [7:0]  out_tag_o,
    output logic        out_last_o,
    output logic        missed_o,
    output logic [15:0] dump_count_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index of the final word: PC + 32 registers + MEM_WORDS memory words.
    localparam logic [7:0] L_IDX     = 8'(32 + MEM_WORDS);
    localparam logic [7:0] REG_FIRST = 8'd1;
    localparam logic [7:0] REG_LAST  = 8'd32;
    localparam logic [7:0] MEM_FIRST = 8'd33;

    state_t      state_q;
    logic [7:0]  idx_q;
    logic [31:0] data_q;
    logic [7:0]  tag_q;
    logic        valid_q;
    logic        last_q;
    logic        freeze_q;
    logic        missed_q;
    logic [15:0] count_q;

    logic [7:0]  idx_d;
    logic [31:0] load_d;

    // Index of the word that the next accepted handshake will load.
    always_comb begin
        idx_d = 8'd0;
        if (state_q == SEND) begin
            idx_d = idx_q + 8'd1;
        end
    end

    // Read addresses decode from state/idx only, so they already point at the
    // next word and stay stable while the current word is stalled.
    always_comb begin
        reg_addr_o = 5'd0;
        mem_addr_o = 32'd0;
        if (idx_d >= REG_FIRST && idx_d <= REG_LAST) begin
            reg_addr_o = 5'(idx_d - REG_FIRST);
        end
        if (idx_d >= MEM_FIRST && idx_d <= L_IDX) begin
            mem_addr_o = {22'd0, idx_d - MEM_FIRST, 2'b00};
        end
    end

    // Select the register or memory port for the next word.
    always_comb begin
        load_d = mem_data_i;
        if (idx_d <= REG_LAST) begin
            load_d = reg_data_i;
        end
    end

    // Dump sequencer: all stream outputs, freeze, missed and counter registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= 8'd0;
            data_q   <= 32'd0;
            tag_q    <= 8'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            freeze_q <= 1'b0;
            missed_q <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            missed_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trig_i) begin
                        state_q  <= SEND;
                        idx_q    <= 8'd0;
                        data_q   <= pc_i;
                        tag_q    <= 8'd0;
                        valid_q  <= 1'b1;
                        last_q   <= 1'b0;
                        freeze_q <= 1'b1;
                    end
                end
                SEND: begin
                    // A trigger during a dump, including its final handshake, is dropped.
                    missed_q <= trig_i;
                    if (valid_q && out_ready_i) begin
                        if (idx_q != L_IDX) begin
                            idx_q  <= idx_d;
                            data_q <= load_d;
                            tag_q  <= idx_d;
                            last_q <= (idx_d == L_IDX);
                        end else begin
                            state_q  <= IDLE;
                            valid_q  <= 1'b0;
                            last_q   <= 1'b0;
                            freeze_q <= 1'b0;
                            count_q  <= count_q + 16'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign freeze_o     = freeze_q;
    assign out_valid_o  = valid_q;
    assign out_data_o   = data_q;
    assign out_tag_o    = tag_q;
    assign out_last_o   = last_q;
    assign missed_o     = missed_q;
    assign dump_count_o = count_q;

endmodule
